c1_zone_decode: RTL and testbench

C1_ZONE_DECODE -- requirements
Module: c1_zone_decode

---
 rtl/c1_zone_decode_pkg.sv | 33 +++
 rtl/c1_zone_lut.sv | 28 ++
 rtl/c1_zone_decode.sv | 110 +++++++++++
 tb/tb_c1_zone_decode.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/c1_zone_decode_pkg.sv
// Shared C1 definitions: CPU address zone nibbles, zone vector layout and the
// bus-cycle FSM encoding used by the zone decoder and the wait-state generator.
package c1_zone_decode_pkg;

    localparam int N_ZONES   = 7;

    // Bit positions inside the active-low zone vector
    localparam int ZONE_ROM  = 0;
    localparam int ZONE_WRAM = 1;
    localparam int ZONE_PORT = 2;
    localparam int ZONE_IO   = 3;
    localparam int ZONE_PAL  = 4;
    localparam int ZONE_CARD = 5;
    localparam int ZONE_SROM = 6;

    localparam logic [3:0] NIB_ROM     = 4'h0;
    localparam logic [3:0] NIB_WRAM    = 4'h1;
    localparam logic [3:0] NIB_PORT    = 4'h2;
    localparam logic [3:0] NIB_IO      = 4'h3;
    localparam logic [3:0] NIB_PAL     = 4'h4;
    localparam logic [3:0] NIB_CARD_LO = 4'h8;
    localparam logic [3:0] NIB_CARD_HI = 4'hB;
    localparam logic [3:0] NIB_SROM    = 4'hC;

    localparam logic [N_ZONES-1:0] ZONES_NONE = '1;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACTIVE = 2'd1,
        ST_BERR   = 2'd2
    } c1State_t;

endpackage

// File: rtl/c1_zone_lut.sv
// Pure combinational A23..A20 nibble to one-hot-low zone vector; unmapped
// nibbles leave every zone deasserted.
module c1_zone_lut
    import c1_zone_decode_pkg::*;
(
    input  logic [3:0]         addrNibble,
    output logic [N_ZONES-1:0] zoneN
);

    always_comb begin
        zoneN = ZONES_NONE;
        if (addrNibble == NIB_ROM)
            zoneN[ZONE_ROM] = 1'b0;
        else if (addrNibble == NIB_WRAM)
            zoneN[ZONE_WRAM] = 1'b0;
        else if (addrNibble == NIB_PORT)
            zoneN[ZONE_PORT] = 1'b0;
        else if (addrNibble == NIB_IO)
            zoneN[ZONE_IO] = 1'b0;
        else if (addrNibble == NIB_PAL)
            zoneN[ZONE_PAL] = 1'b0;
        else if (addrNibble >= NIB_CARD_LO && addrNibble <= NIB_CARD_HI)
            zoneN[ZONE_CARD] = 1'b0;
        else if (addrNibble == NIB_SROM)
            zoneN[ZONE_SROM] = 1'b0;
    end

endmodule

// File: rtl/c1_zone_decode.sv
// C1 address zone decoder: registered zone selects latched at address strobe,
// plus a bus-cycle watchdog that raises nBERR when DTACK never arrives.
module c1_zone_decode
    import c1_zone_decode_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 64,
    parameter int CNT_W          = 7
) (
    input  logic       CLK_68KCLK,
    input  logic       nRESET,
    input  logic [3:0] M68K_ADDR,
    input  logic       nAS,
    input  logic       nDTACK,
    output logic       nROM_ZONE,
    output logic       nWRAM_ZONE,
    output logic       nPORT_ZONE,
    output logic       nIO_ZONE,
    output logic       nPAL_ZONE,
    output logic       nCARD_ZONE,
    output logic       nSROM_ZONE,
    output logic       nVALID,
    output logic       nBERR
);

    localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    logic [N_ZONES-1:0] lutZoneN;
    logic [N_ZONES-1:0] zoneReg;
    logic               zoneMapped;
    c1State_t           state;
    logic [CNT_W-1:0]   count;
    logic               nValidReg;
    logic               nBerrReg;

    c1_zone_lut uLut (
        .addrNibble (M68K_ADDR),
        .zoneN      (lutZoneN)
    );

    // Zones follow the address only while the strobe is high, so the select
    // is stable for the whole cycle once the CPU commits to it.
    always_ff @(posedge CLK_68KCLK) begin
        if (!nRESET)
            zoneReg <= ZONES_NONE;
        else if (nAS)
            zoneReg <= lutZoneN;
    end

    assign zoneMapped = ~&zoneReg;

    always_ff @(posedge CLK_68KCLK) begin
        if (!nRESET) begin
            state     <= ST_IDLE;
            count     <= '0;
            nValidReg <= 1'b1;
            nBerrReg  <= 1'b1;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (!nAS) begin
                        state     <= ST_ACTIVE;
                        count     <= '0;
                        nValidReg <= ~zoneMapped;
                        nBerrReg  <= 1'b1;
                    end
                end
                // DTACK wins over the timeout: the limit is only acted on when
                // nDTACK is still high on the deciding edge.
                ST_ACTIVE: begin
                    if (nAS) begin
                        state     <= ST_IDLE;
                        nValidReg <= 1'b1;
                        nBerrReg  <= 1'b1;
                    end else if (nDTACK) begin
                        if (count == CNT_LIMIT) begin
                            state    <= ST_BERR;
                            nBerrReg <= 1'b0;
                        end else if (count != CNT_MAX) begin
                            count <= count + CNT_W'(1);
                        end
                    end
                end
                ST_BERR: begin
                    if (nAS) begin
                        state     <= ST_IDLE;
                        nValidReg <= 1'b1;
                        nBerrReg  <= 1'b1;
                    end
                end
                default: begin
                    state     <= ST_IDLE;
                    nValidReg <= 1'b1;
                    nBerrReg  <= 1'b1;
                end
            endcase
        end
    end

    assign nROM_ZONE  = zoneReg[ZONE_ROM];
    assign nWRAM_ZONE = zoneReg[ZONE_WRAM];
    assign nPORT_ZONE = zoneReg[ZONE_PORT];
    assign nIO_ZONE   = zoneReg[ZONE_IO];
    assign nPAL_ZONE  = zoneReg[ZONE_PAL];
    assign nCARD_ZONE = zoneReg[ZONE_CARD];
    assign nSROM_ZONE = zoneReg[ZONE_SROM];
    assign nVALID     = nValidReg;
    assign nBERR      = nBerrReg;

endmodule

// File: tb/tb_c1_zone_decode.sv
// Directed bench for c1_zone_decode: reset, zone latching, address hold,
// timeout to bus error, DTACK/timeout race, mid-cycle reset and a zone sweep.
module tb_c1_zone_decode;

    logic       clk = 1'b0;
    logic       nReset;
    logic [3:0] addr;
    logic       nAs;
    logic       nDtack;
    logic       nRom, nWram, nPort, nIo, nPal, nCard, nSrom, nValid, nBerr;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    c1_zone_decode #(.TIMEOUT_CYCLES(64), .CNT_W(7)) dut (
        .CLK_68KCLK (clk),
        .nRESET     (nReset),
        .M68K_ADDR  (addr),
        .nAS        (nAs),
        .nDTACK     (nDtack),
        .nROM_ZONE  (nRom),
        .nWRAM_ZONE (nWram),
        .nPORT_ZONE (nPort),
        .nIO_ZONE   (nIo),
        .nPAL_ZONE  (nPal),
        .nCARD_ZONE (nCard),
        .nSROM_ZONE (nSrom),
        .nVALID     (nValid),
        .nBERR      (nBerr)
    );

    function automatic logic [6:0] zones();
        return {nSrom, nCard, nPal, nIo, nPort, nWram, nRom};
    endfunction

    // Hand-written zone table, bit order {SROM,CARD,PAL,IO,PORT,WRAM,ROM}
    function automatic logic [6:0] expZone(input logic [3:0] nib);
        case (nib)
            4'h0:                   return 7'b1111110;
            4'h1:                   return 7'b1111101;
            4'h2:                   return 7'b1111011;
            4'h3:                   return 7'b1110111;
            4'h4:                   return 7'b1101111;
            4'h8, 4'h9, 4'hA, 4'hB: return 7'b1011111;
            4'hC:                   return 7'b0111111;
            default:                return 7'b1111111;
        endcase
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic applyStimulus(input logic [3:0] a, input logic asN, input logic dtN);
        addr   = a;
        nAs    = asN;
        nDtack = dtN;
    endtask

    task automatic test_reset();
        nReset = 1'b0;
        applyStimulus(4'h0, 1'b0, 1'b0);
        step();
        step();
        total++; if (zones() !== 7'h7F) begin bad++; $display("[TB] FAIL reset_zones got=%b want=%b", zones(), 7'h7F); end
        total++; if (nValid !== 1'b1) begin bad++; $display("[TB] FAIL reset_nvalid got=%b want=1", nValid); end
        total++; if (nBerr !== 1'b1) begin bad++; $display("[TB] FAIL reset_nberr got=%b want=1", nBerr); end
        applyStimulus(4'h0, 1'b1, 1'b1);
        nReset = 1'b1;
        step();
    endtask

    task automatic test_rom_cycle();
        applyStimulus(4'h0, 1'b1, 1'b1);
        step();
        total++; if (zones() !== 7'b1111110) begin bad++; $display("[TB] FAIL rom_cycle1 got=%b want=%b", zones(), 7'b1111110); end
        step();
        applyStimulus(4'h0, 1'b0, 1'b1);
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (nValid !== 1'b0) begin bad++; $display("[TB] FAIL rom_nvalid k=%0d got=%b want=0", k, nValid); end
            total++; if (nBerr !== 1'b1) begin bad++; $display("[TB] FAIL rom_nberr k=%0d got=%b want=1", k, nBerr); end
        end
        nDtack = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            total++; if (zones() !== 7'b1111110 || nBerr !== 1'b1) begin bad++; $display("[TB] FAIL rom_dtack k=%0d got=%b/%b want=%b/1", k, zones(), nBerr, 7'b1111110); end
        end
        applyStimulus(4'h0, 1'b1, 1'b1);
        step();
        total++; if (nValid !== 1'b1) begin bad++; $display("[TB] FAIL rom_end_nvalid got=%b want=1", nValid); end
    endtask

    task automatic test_addr_hold();
        applyStimulus(4'h2, 1'b1, 1'b1);
        step();
        applyStimulus(4'h4, 1'b0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            total++; if (nPort !== 1'b0 || nPal !== 1'b1) begin bad++; $display("[TB] FAIL hold k=%0d port=%b pal=%b want port=0 pal=1", k, nPort, nPal); end
        end
        nAs = 1'b1;
        step();
        total++; if (zones() !== 7'b1101111) begin bad++; $display("[TB] FAIL hold_release got=%b want=%b", zones(), 7'b1101111); end
        total++; if (nValid !== 1'b1) begin bad++; $display("[TB] FAIL hold_release_nvalid got=%b want=1", nValid); end
    endtask

    task automatic test_unmapped_timeout();
        applyStimulus(4'h6, 1'b1, 1'b1);
        step();
        nAs = 1'b0;
        for (int k = 0; k < 70; k++) begin
            if (k == 66) nDtack = 1'b0;
            step();
            total++; if (nBerr !== ((k >= 64) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL timeout_nberr edge=%0d got=%b want=%b", k, nBerr, (k >= 64) ? 1'b0 : 1'b1); end
            total++; if (zones() !== 7'h7F || nValid !== 1'b1) begin bad++; $display("[TB] FAIL timeout_zones edge=%0d got=%b/%b want=%b/1", k, zones(), nValid, 7'h7F); end
        end
        applyStimulus(4'h6, 1'b1, 1'b1);
        step();
        total++; if (nBerr !== 1'b1) begin bad++; $display("[TB] FAIL timeout_release got=%b want=1", nBerr); end
    endtask

    task automatic test_dtack_race();
        applyStimulus(4'h9, 1'b1, 1'b1);
        step();
        nAs = 1'b0;
        for (int k = 0; k < 64; k++) begin
            step();
            total++; if (nBerr !== 1'b1) begin bad++; $display("[TB] FAIL race_pre edge=%0d got=%b want=1", k, nBerr); end
        end
        nDtack = 1'b0;
        for (int k = 64; k < 71; k++) begin
            step();
            total++; if (nBerr !== 1'b1) begin bad++; $display("[TB] FAIL race_nberr edge=%0d got=%b want=1", k, nBerr); end
            total++; if (nCard !== 1'b0 || nValid !== 1'b0) begin bad++; $display("[TB] FAIL race_card edge=%0d card=%b valid=%b want 0/0", k, nCard, nValid); end
        end
        applyStimulus(4'h9, 1'b1, 1'b1);
        step();
    endtask

    task automatic test_reset_mid_cycle();
        applyStimulus(4'h1, 1'b1, 1'b1);
        step();
        nAs = 1'b0;
        for (int k = 0; k <= 40; k++) step();
        total++; if (nWram !== 1'b0 || nValid !== 1'b0) begin bad++; $display("[TB] FAIL midrst_pre wram=%b valid=%b want 0/0", nWram, nValid); end
        nReset = 1'b0;
        step();
        total++; if (zones() !== 7'h7F || nValid !== 1'b1 || nBerr !== 1'b1) begin bad++; $display("[TB] FAIL midrst_outputs got=%b/%b/%b want=%b/1/1", zones(), nValid, nBerr, 7'h7F); end
        nReset = 1'b1;
        for (int k = 0; k <= 64; k++) begin
            step();
            total++; if (nBerr !== ((k >= 64) ? 1'b0 : 1'b1)) begin bad++; $display("[TB] FAIL midrst_count edge=%0d got=%b want=%b", k, nBerr, (k >= 64) ? 1'b0 : 1'b1); end
            total++; if (zones() !== 7'h7F || nValid !== 1'b1) begin bad++; $display("[TB] FAIL midrst_zones edge=%0d got=%b/%b want=%b/1", k, zones(), nValid, 7'h7F); end
        end
        applyStimulus(4'h1, 1'b1, 1'b1);
        step();
        total++; if (nWram !== 1'b0 || nBerr !== 1'b1) begin bad++; $display("[TB] FAIL midrst_release wram=%b berr=%b want 0/1", nWram, nBerr); end
    endtask

    task automatic test_sweep();
        logic [3:0] a;
        for (int i = 0; i < 16; i++) begin
            a = 4'(i);
            applyStimulus(a, 1'b1, 1'b1);
            step();
            total++; if (zones() !== expZone(a)) begin bad++; $display("[TB] FAIL sweep addr=%h got=%b want=%b", a, zones(), expZone(a)); end
            total++; if (nValid !== 1'b1 || nBerr !== 1'b1) begin bad++; $display("[TB] FAIL sweep_ctrl addr=%h valid=%b berr=%b want 1/1", a, nValid, nBerr); end
        end
    endtask

    initial begin
        nReset = 1'b0;
        applyStimulus(4'h0, 1'b1, 1'b1);
        test_reset();
        test_rom_cycle();
        test_addr_hold();
        test_unmapped_timeout();
        test_dtack_race();
        test_reset_mid_cycle();
        test_sweep();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
